// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max/threshold tracker: FSM states and
// default parameter values.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam int W_DEF       = 4;
    localparam int RUN_LEN_DEF = 3;
    localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/mag_compare.sv
// Unsigned W-bit magnitude comparator: a against b.
module mag_compare #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Tracks running max/min of accepted samples, counts samples above a threshold,
// and raises a held alarm after RUN_LEN consecutive above-threshold samples.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [W-1:0]     thresh,
    input  logic             clear,
    input  logic             alarm_ack,
    output logic             out_valid,
    output logic [W-1:0]     max_out,
    output logic [W-1:0]     min_out,
    output logic [CNT_W-1:0] gt_cnt,
    output logic             alarm
);

    localparam int             RUN_W   = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    state_t           state, state_next;
    logic [RUN_W-1:0] run, run_next;
    logic             accept, above, hit;
    logic             max_gt, max_eq, max_lt;
    logic             min_gt, min_eq, min_lt;
    logic             thr_gt, thr_eq, thr_lt;
    logic             unused_cmp;

    mag_compare #(.W(W)) u_cmp_max (.a(in_data), .b(max_out), .gt(max_gt), .eq(max_eq), .lt(max_lt));
    mag_compare #(.W(W)) u_cmp_min (.a(in_data), .b(min_out), .gt(min_gt), .eq(min_eq), .lt(min_lt));
    mag_compare #(.W(W)) u_cmp_thr (.a(in_data), .b(thresh),  .gt(thr_gt), .eq(thr_eq), .lt(thr_lt));

    // Only the strict relations drive updates; equality leaves registers alone.
    assign unused_cmp = &{max_eq, max_lt, min_gt, min_eq, thr_eq, thr_lt};

    assign in_ready = !clear && (state != ALARM);
    assign accept   = in_valid && in_ready;
    assign above    = thr_gt;
    assign run_next = above ? ((run == RUN_MAX) ? run : run + RUN_W'(1)) : '0;
    assign hit      = accept && above && (run_next == RUN_MAX);

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = hit ? ALARM : TRACK;
                TRACK:   if (hit) state_next = ALARM;
                ALARM:   if (alarm_ack) state_next = TRACK;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            max_out   <= '0;
            min_out   <= '1;
            gt_cnt    <= '0;
            run       <= '0;
            alarm     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= accept;
            if (clear) begin
                max_out <= '0;
                min_out <= '1;
                gt_cnt  <= '0;
                run     <= '0;
                alarm   <= 1'b0;
            end else if (state == ALARM) begin
                if (alarm_ack) begin
                    run   <= '0;
                    alarm <= 1'b0;
                end
            end else if (accept) begin
                // First sample after reset/clear seeds both extremes.
                if (state == IDLE) begin
                    max_out <= in_data;
                    min_out <= in_data;
                end else begin
                    if (max_gt) max_out <= in_data;
                    if (min_lt) min_out <= in_data;
                end
                run <= run_next;
                if (above && (gt_cnt != '1)) gt_cnt <= gt_cnt + CNT_W'(1);
                if (hit) alarm <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_minmax_tracker.sv
// Bench for minmax_tracker: two instances (CNT_W=8 and CNT_W=2) driven with the
// same stimulus and compared against a history-based reference model.
module tb_minmax_tracker;

    localparam int W       = 4;
    localparam int RUN_LEN = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] thresh = '0;
    logic         clear = 1'b0;
    logic         alarm_ack = 1'b0;

    logic         in_ready, out_valid, alarm;
    logic [W-1:0] max_out, min_out;
    logic [7:0]   gt_cnt;

    logic         in_ready2, out_valid2, alarm2;
    logic [W-1:0] max_out2, min_out2;
    logic [1:0]   gt_cnt2;

    int total = 0;
    int bad   = 0;

    // Reference model state: samples accepted since last reset/clear.
    int hist[$];
    int m_gt    = 0;
    int m_trail = 0;
    bit m_alarm = 0;
    bit m_ov    = 0;

    minmax_tracker #(.W(W), .RUN_LEN(RUN_LEN), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .thresh(thresh), .clear(clear), .alarm_ack(alarm_ack),
        .out_valid(out_valid), .max_out(max_out), .min_out(min_out),
        .gt_cnt(gt_cnt), .alarm(alarm)
    );

    minmax_tracker #(.W(W), .RUN_LEN(RUN_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .thresh(thresh), .clear(clear), .alarm_ack(alarm_ack),
        .out_valid(out_valid2), .max_out(max_out2), .min_out(min_out2),
        .gt_cnt(gt_cnt2), .alarm(alarm2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_gt    = 0;
        m_trail = 0;
        m_alarm = 0;
        m_ov    = 0;
    endtask

    function automatic int exp_max();
        int r = 0;
        foreach (hist[i]) if (hist[i] > r) r = hist[i];
        return r;
    endfunction

    function automatic int exp_min();
        int r = (1 << W) - 1;
        foreach (hist[i]) if (hist[i] < r) r = hist[i];
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, ".max"},       32'(max_out),   32'(exp_max()));
        chk({tag, ".min"},       32'(min_out),   32'(exp_min()));
        chk({tag, ".gt_cnt"},    32'(gt_cnt),    32'((m_gt > 255) ? 255 : m_gt));
        chk({tag, ".alarm"},     32'(alarm),     32'(m_alarm));
        chk({tag, ".sat_gt"},    32'(gt_cnt2),   32'((m_gt > 3) ? 3 : m_gt));
        chk({tag, ".sat_alarm"}, 32'(alarm2),    32'(m_alarm));
        chk({tag, ".sat_max"},   32'(max_out2),  32'(exp_max()));
    endtask

    // Called at posedge+1: drive one cycle of inputs, check ready, clock, check outputs.
    task automatic step(input string tag, input bit v, input int d, input int th,
                        input bit clr, input bit ack);
        bit exp_ready, acc;
        in_valid  = v;
        in_data   = W'(d);
        thresh    = W'(th);
        clear     = clr;
        alarm_ack = ack;
        #1;
        exp_ready = !clr && !m_alarm;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        chk({tag, ".sat_ready"}, 32'(in_ready2), 32'(exp_ready));
        acc = v && exp_ready;
        if (clr) begin
            model_reset();
        end else if (m_alarm) begin
            m_ov = 0;
            if (ack) begin
                m_alarm = 0;
                m_trail = 0;
            end
        end else if (acc) begin
            hist.push_back(d);
            if (d > th) begin
                m_gt++;
                m_trail++;
                if (m_trail >= RUN_LEN) m_alarm = 1;
            end else begin
                m_trail = 0;
            end
            m_ov = 1;
        end else begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic tracking with thresh 8
        step("s1a", 1, 5, 8, 0, 0);
        step("s1b", 1, 12, 8, 0, 0);
        step("s1c", 1, 3, 8, 0, 0);
        chk("s1.max_const", 32'(max_out), 32'd12);
        chk("s1.min_const", 32'(min_out), 32'd3);
        chk("s1.gt_const",  32'(gt_cnt),  32'd1);
        step("idle", 0, 0, 8, 0, 0);

        // Run broken by an equal-to-threshold sample, alarm on the sixth
        step("clr2", 0, 0, 8, 1, 0);
        step("s2a", 1, 9, 8, 0, 0);
        step("s2b", 1, 10, 8, 0, 0);
        step("s2c", 1, 8, 8, 0, 0);
        step("s2d", 1, 9, 8, 0, 0);
        step("s2e", 1, 11, 8, 0, 0);
        chk("s2.no_alarm_yet", 32'(alarm), 32'd0);
        step("s2f", 1, 15, 8, 0, 0);
        chk("s2.alarm_const", 32'(alarm), 32'd1);
        chk("s2.gt_const",    32'(gt_cnt), 32'd5);

        // Samples ignored while in ALARM, then acknowledge
        for (int i = 0; i < 4; i++) step("s3hold", 1, 2, 8, 0, 0);
        chk("s3.min_const", 32'(min_out), 32'd8);
        step("s3ack", 1, 2, 8, 0, 1);
        chk("s3.alarm_off", 32'(alarm), 32'd0);
        step("s3ready", 0, 0, 8, 0, 0);
        step("s3ack_ignored", 1, 4, 8, 0, 1);

        // Counter saturation on the narrow instance
        step("clr4", 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("s4a", 1, 1, 0, 0, 0);
        step("s4ack", 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) step("s4b", 1, 1, 0, 0, 0);
        chk("s4.sat_const", 32'(gt_cnt2), 32'd3);
        chk("s4.wide_const", 32'(gt_cnt), 32'd5);

        // Clear with a sample in the same cycle, then an IDLE-style reload
        step("s5pre", 1, 13, 15, 0, 0);
        step("s5clr", 1, 7, 15, 1, 0);
        chk("s5.max_const", 32'(max_out), 32'd0);
        chk("s5.min_const", 32'(min_out), 32'd15);
        chk("s5.ov_const",  32'(out_valid), 32'd0);
        step("s5next", 1, 9, 15, 0, 0);

        // Clear together with ack from ALARM
        for (int i = 0; i < 3; i++) step("s5run", 1, 14, 2, 0, 0);
        step("s5clr_ack", 1, 3, 2, 1, 1);
        step("s5after", 1, 4, 8, 0, 0);

        // Asynchronous reset in the middle of an ALARM cycle
        for (int i = 0; i < 3; i++) step("s6run", 1, 9, 8, 0, 0);
        chk("s6.in_alarm", 32'(alarm), 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("s6rst");
        chk("s6.ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("s6first", 1, 6, 8, 0, 0);
        chk("s6.max_const", 32'(max_out), 32'd6);
        chk("s6.min_const", 32'(min_out), 32'd6);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit v, clr, ack;
            int d, th;
            v   = ($urandom_range(0, 3) != 0);
            d   = $urandom_range(0, 15);
            th  = $urandom_range(0, 15);
            clr = ($urandom_range(0, 40) == 0);
            ack = m_alarm ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            step("rand", v, d, th, clr, ack);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
